axi_rd_resp_sram: RTL

- AXI4 read-channel responder (slave) that serves instruction and data read bursts from a synchronous single-port SRAM.
- It is the target end of the read interface driven by the IF-stage cache fetch logic: it accepts AR requests, walks FIXED/INCR/WRAP burst addresses, and returns R beats with RRESP.
- It is used as the SDRAM-region backing store in simulation and FPGA builds.

---
 rtl/axi_rd_resp_sram.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/axi_rd_resp_sram.sv
// AXI4 read-channel slave serving FIXED/INCR/WRAP bursts from a synchronous single-port SRAM.
// Optional AXI_RD_RESP_RAND_DLY_EN adds an LFSR-driven wait before every beat.
module axi_rd_resp_sram #(
    parameter logic [31:0] BASE_ADDR = 32'ha000_0000,
    parameter int          MEM_AW    = 16,
    parameter int          FIRST_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              arvalid,
    output logic              arready,
    input  logic [31:0]       araddr,
    input  logic [3:0]        arid,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    output logic              rvalid,
    input  logic              rready,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic [3:0]        rid,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RD, S_RESP} state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_addr;
    logic [3:0]  r_id;
    logic [7:0]  r_len, r_cnt;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic        r_legal;
    logic [4:0]  r_dly;
    logic [1:0]  r_rresp;
    logic        r_beat_ok;
    logic        r_fresh;
    logic [31:0] r_rdata;

    logic [31:0] w_off, w_bytes, w_wb, w_next_addr, w_rdata;
    logic        w_in_range, w_ar_legal, w_last;
    logic [4:0]  w_first_dly, w_beat_dly;

`ifdef AXI_RD_RESP_RAND_DLY_EN
    logic [3:0] r_lfsr;

    // x^4 + x^3 + 1, free-running so the inserted gaps are pseudo-random per beat
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_lfsr <= 4'b1001;
        else        r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
    end

    assign w_first_dly = 5'(FIRST_LAT) + {1'b0, r_lfsr};
    assign w_beat_dly  = {1'b0, r_lfsr};
`else
    assign w_first_dly = 5'(FIRST_LAT);
    assign w_beat_dly  = 5'd0;
`endif

    assign w_ar_legal = (arsize <= 3'd2) && (arburst != 2'b11) &&
                        ((arburst != 2'b10) || (arlen == 8'd1) || (arlen == 8'd3) ||
                         (arlen == 8'd7) || (arlen == 8'd15));

    // Unsigned offset test also rejects addresses below the base (they wrap high)
    assign w_off      = r_addr - BASE_ADDR;
    assign w_in_range = (w_off >> (MEM_AW + 2)) == 32'd0;
    assign w_last     = (r_cnt == 8'd0);
    assign w_bytes    = 32'd1 << r_size;
    assign w_wb       = ({24'd0, r_len} + 32'd1) << r_size;

    always_comb begin
        case (r_burst)
            2'b01:   w_next_addr = r_addr + w_bytes;
            2'b10:   w_next_addr = (r_addr & ~(w_wb - 32'd1)) | ((r_addr + w_bytes) & (w_wb - 32'd1));
            default: w_next_addr = r_addr;
        endcase
    end

    // SRAM data is only valid on the first RESP cycle; afterwards the captured copy is held
    assign w_rdata = r_fresh ? (r_beat_ok ? mem_rdata : 32'd0) : r_rdata;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (arvalid) w_state_next = (w_first_dly == 5'd0) ? S_RD : S_WAIT;
            S_WAIT: if (r_dly <= 5'd1) w_state_next = S_RD;
            S_RD:   w_state_next = S_RESP;
            S_RESP: if (rready) w_state_next = w_last ? S_IDLE :
                                               ((w_beat_dly == 5'd0) ? S_RD : S_WAIT);
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        arready  = (r_state == S_IDLE);
        rvalid   = (r_state == S_RESP);
        rlast    = (r_state == S_RESP) && w_last;
        mem_en   = (r_state == S_RD) && r_legal && w_in_range;
        mem_addr = mem_en ? w_off[MEM_AW+1:2] : '0;
        rdata    = w_rdata;
        rresp    = r_rresp;
        rid      = r_id;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_addr    <= '0;
            r_id      <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_legal   <= 1'b0;
            r_dly     <= '0;
            r_rresp   <= '0;
            r_beat_ok <= 1'b0;
            r_fresh   <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_fresh <= 1'b0;
            case (r_state)
                S_IDLE: if (arvalid) begin
                    r_addr  <= araddr;
                    r_id    <= arid;
                    r_len   <= arlen;
                    r_cnt   <= arlen;
                    r_size  <= arsize;
                    r_burst <= arburst;
                    r_legal <= w_ar_legal;
                    r_dly   <= w_first_dly;
                end
                S_WAIT: r_dly <= r_dly - 5'd1;
                S_RD: begin
                    r_fresh   <= 1'b1;
                    r_beat_ok <= r_legal && w_in_range;
                    r_rresp   <= !r_legal ? 2'b10 : (w_in_range ? 2'b00 : 2'b11);
                end
                S_RESP: begin
                    r_rdata <= w_rdata;
                    if (rready && !w_last) begin
                        r_cnt  <= r_cnt - 8'd1;
                        r_addr <= w_next_addr;
                        r_dly  <= w_beat_dly;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
